dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
Write-back, write-allocate L1 data-cache controller for the pipelined CPU. It accepts 32-bit CPU load/store requests and drives the 2-way tag/data storage array, which owns hit detection and LRU. On a miss it evicts a dirty victim to data memory over the 256-bit line bus, refills the line, then lets the stalled access complete as a hit.

Parameters:
TAG_W, 23, address tag width, cpu_addr_i[31:9]
INDEX_W, 4, set index width, cpu_addr_i[8:5], 16 sets
OFFSET_W, 5, byte offset in a 32-byte line; TAG_W+INDEX_W+OFFSET_W must equal 32

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
cpu_addr_i  in  32  byte address, word aligned
cpu_data_i  in  32  store data
cpu_MemRead_i  in  1  load request, held until stall drops
cpu_MemWrite_i  in  1  store request, held until stall drops
cpu_data_o  out  32  load data
cpu_stall_o  out  1  CPU must hold request and freeze pipeline
mem_data_i  in  256  refill line
mem_ack_i  in  1  one-cycle pulse: current memory transaction done
mem_addr_o  out  32  line address, [4:0]=0
mem_data_o  out  256  writeback line
mem_enable_o  out  1  memory transaction request
mem_write_o  out  1  1=writeback, 0=refill
sram_index_o  out  4  set index to storage
sram_tag_o  out  25  {valid,dirty,tag[22:0]} to storage
sram_data_o  out  256  line data to storage
sram_enable_o  out  1  storage access
sram_write_o  out  1  storage write strobe
sram_tag_i  in  25  hit: matching way's tag; miss: LRU victim's tag
sram_data_i  in  256  hit: matching line; miss: LRU victim's line
sram_hit_i  in  1  storage hit flag, combinational

Behaviour:
- req = cpu_MemRead_i | cpu_MemWrite_i. sram_enable_o = req. sram_index_o = addr[8:5] in all states.
- Word select k = addr[4:2]. Load data = sram_data_i[32k+31:32k].
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE. Reset state is IDLE.
- IDLE:
  - No req: idle.
  - Read hit: cpu_data_o valid in the same cycle; cpu_stall_o=0.
  - Write hit: sram_write_o=1; sram_data_o = sram_data_i with word k replaced by cpu_data_i; sram_tag_o = {1,1,addr[31:9]}; cpu_stall_o=0.
  - req & !sram_hit_i: cpu_stall_o=1, go to MISS.
- MISS (1 cycle, stall=1):
  - If sram_tag_i[24] & sram_tag_i[23] (valid and dirty): latch victim line to mem_data_o; mem_addr_o={sram_tag_i[22:0],index,5'b0}; mem_enable_o=1; mem_write_o=1; go to WRITEBACK.
  - Otherwise: mem_addr_o={addr[31:9],index,5'b0}; mem_enable_o=1; mem_write_o=0; go to REFILL.
- WRITEBACK: hold mem_enable_o, mem_write_o, mem_addr_o and mem_data_o stable until mem_ack_i. On ack, switch in the next cycle to a refill request (mem_write_o=0, miss address) and go to REFILL.
- REFILL: hold the request until mem_ack_i. On ack:
  - sram_write_o=1, sram_data_o=mem_data_i, sram_tag_o={1,0,addr[31:9]}.
  - mem_enable_o drops next cycle; go to REFILL_DONE.
  - A store completes on the following IDLE hit, which sets dirty.
- REFILL_DONE: stall=1, one cycle, then IDLE. The lookup in IDLE hits and releases the stall.
- cpu_stall_o is 1 in every non-IDLE state.
- mem_ack_i is ignored in IDLE, MISS and REFILL_DONE.
- mem_enable_o is never asserted without a pending transaction. It is never dropped before ack.
- CPU address and control are assumed stable while stalled; the controller does not latch them.
- Reset low at any time: immediate return to IDLE; mem_enable_o, mem_write_o, sram_write_o, cpu_stall_o = 0; mem_addr_o, mem_data_o, cpu_data_o = 0. An in-flight memory transaction is abandoned, and any later ack is ignored.

Test Plan:
1. Reset, then load 0x0000_0004 into the empty cache -> stall=1; MISS, then REFILL with mem_addr_o=0x0, mem_write_o=0. Ack with line word1=0xDEADBEEF -> after REFILL_DONE stall=0, cpu_data_o=0xDEADBEEF.
2. Load the same address again -> hit, no memory request, stall=0 in the same cycle, data 0xDEADBEEF.
3. Store 0x12345678 to 0x0000_0008 (hit) -> single-cycle sram_write_o; tag {1,1,0}; word2 updated, other words unchanged; stall=0.
4. Fill both ways of set 0 (0x0000 dirty, 0x0200), then load 0x0400 with way 0 as LRU:
   - WRITEBACK first: mem_addr_o=0x0, mem_write_o=1, data includes 0x12345678, held 5 cycles until ack.
   - Then REFILL at 0x0400.
5. Delay mem_ack_i 10 cycles in REFILL; pulse a spurious ack in IDLE -> request held stable, stall held; the spurious ack causes no state change.
6. Assert rst_i low during WRITEBACK -> all outputs 0 within the reset; release -> IDLE; a later ack is ignored.

Source files
------------

// File: rtl/dcache_controller.sv
// Write-back, write-allocate L1 data-cache controller.
// The 2-way storage array resolves hits and LRU; this block sequences misses, writebacks and refills.
module dcache_controller #(
    parameter int TAG_W    = 23,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    input  logic [255:0]         mem_data_i,
    input  logic                 mem_ack_i,
    output logic [31:0]          mem_addr_o,
    output logic [255:0]         mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [INDEX_W-1:0]   sram_index_o,
    output logic [TAG_W+1:0]     sram_tag_o,
    output logic [255:0]         sram_data_o,
    output logic                 sram_enable_o,
    output logic                 sram_write_o,
    input  logic [TAG_W+1:0]     sram_tag_i,
    input  logic [255:0]         sram_data_i,
    input  logic                 sram_hit_i
);

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        REFILL,
        REFILL_DONE
    } state_t;

    state_t state, state_next;

    logic                  req;
    logic [TAG_W-1:0]      addr_tag;
    logic [INDEX_W-1:0]    index;
    logic [OFFSET_W-3:0]   word_sel;
    logic [31:0]           miss_addr;
    logic [31:0]           victim_addr;
    logic                  victim_dirty;
    logic [255:0]          merged_line;
    logic                  stall;
    logic                  write;
    logic                  unused_addr_bits;

    assign req          = cpu_MemRead_i | cpu_MemWrite_i;
    assign addr_tag     = cpu_addr_i[31 -: TAG_W];
    assign index        = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign word_sel     = cpu_addr_i[OFFSET_W-1:2];
    assign miss_addr    = {addr_tag, index, {OFFSET_W{1'b0}}};
    assign victim_addr  = {sram_tag_i[TAG_W-1:0], index, {OFFSET_W{1'b0}}};
    assign victim_dirty = sram_tag_i[TAG_W+1] & sram_tag_i[TAG_W];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign sram_enable_o = req;
    assign sram_index_o  = index;

    always_comb begin
        merged_line = sram_data_i;
        merged_line[{word_sel, 5'b0} +: 32] = cpu_data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        write       = 1'b0;
        sram_tag_o  = {1'b1, 1'b0, addr_tag};
        sram_data_o = sram_data_i;
        case (state)
            IDLE: begin
                if (req && sram_hit_i) begin
                    if (cpu_MemWrite_i) begin
                        write       = 1'b1;
                        sram_data_o = merged_line;
                        sram_tag_o  = {1'b1, 1'b1, addr_tag};
                    end
                end else if (req) begin
                    stall      = 1'b1;
                    state_next = MISS;
                end
            end
            MISS: begin
                stall      = 1'b1;
                state_next = victim_dirty ? WRITEBACK : REFILL;
            end
            WRITEBACK: begin
                stall = 1'b1;
                if (mem_ack_i) state_next = REFILL;
            end
            REFILL: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    write       = 1'b1;
                    sram_data_o = mem_data_i;
                    sram_tag_o  = {1'b1, 1'b0, addr_tag};
                    state_next  = REFILL_DONE;
                end
            end
            REFILL_DONE: begin
                stall      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset must force the CPU-facing strobes low even while a request is presented.
    assign cpu_stall_o  = rst_i & stall;
    assign sram_write_o = rst_i & write;
    assign cpu_data_o   = rst_i ? sram_data_i[{word_sel, 5'b0} +: 32] : 32'h0;

    // Memory request registers: held stable from MISS until the matching ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= 32'h0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                MISS: begin
                    mem_enable_o <= 1'b1;
                    if (victim_dirty) begin
                        mem_write_o <= 1'b1;
                        mem_addr_o  <= victim_addr;
                        mem_data_o  <= sram_data_i;
                    end else begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= miss_addr;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= miss_addr;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) mem_enable_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a behavioural 2-way LRU storage array.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [3:0]   sram_index_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] LINE1 = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                                      32'h3333_0003, 32'h2222_0002, 32'hDEAD_BEEF, 32'h0000_0000};
    localparam logic [255:0] LINE1_ST = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                                         32'h3333_0003, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0000};
    localparam logic [255:0] LINE2 = {32'h2000_0007, 32'h2000_0006, 32'h2000_0005, 32'h2000_0004,
                                      32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
    localparam logic [255:0] LINE3 = {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004,
                                      32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};

    dcache_controller dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .sram_index_o   (sram_index_o),
        .sram_tag_o     (sram_tag_o),
        .sram_data_o    (sram_data_o),
        .sram_enable_o  (sram_enable_o),
        .sram_write_o   (sram_write_o),
        .sram_tag_i     (sram_tag_i),
        .sram_data_i    (sram_data_i),
        .sram_hit_i     (sram_hit_i)
    );

    always #5 clk_i = ~clk_i;

    // Storage array model: entry = {valid, dirty, tag}; m_lru holds the way to evict next.
    logic [24:0]  m_tag  [16][2];
    logic [255:0] m_data [16][2];
    logic         m_lru  [16];
    logic         m_way;
    logic         m_h0;
    logic         m_h1;

    initial begin
        for (int s = 0; s < 16; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_tag[s][w]  = '0;
                m_data[s][w] = '0;
            end
        end
    end

    always_comb begin
        m_h0 = m_tag[sram_index_o][0][24] && (m_tag[sram_index_o][0][22:0] == cpu_addr_i[31:9]);
        m_h1 = m_tag[sram_index_o][1][24] && (m_tag[sram_index_o][1][22:0] == cpu_addr_i[31:9]);
        sram_hit_i  = m_h0 | m_h1;
        m_way       = m_h0 ? 1'b0 : (m_h1 ? 1'b1 : m_lru[sram_index_o]);
        sram_tag_i  = m_tag[sram_index_o][m_way];
        sram_data_i = m_data[sram_index_o][m_way];
    end

    always @(posedge clk_i) begin
        if (sram_enable_o) begin
            if (sram_write_o) begin
                m_tag[sram_index_o][m_way]  <= sram_tag_o;
                m_data[sram_index_o][m_way] <= sram_data_o;
            end
            if (sram_write_o || sram_hit_i) m_lru[sram_index_o] <= ~m_way;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_mem_enable(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (mem_enable_o) break;
            tick();
        end
        check(tag, mem_enable_o, 1'b1);
    endtask

    task automatic hold_stable(input string tag, input int cycles);
        logic         ok;
        logic [31:0]  a;
        logic [255:0] d;
        logic         w;
        ok = 1'b1;
        a  = mem_addr_o;
        d  = mem_data_o;
        w  = mem_write_o;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (!mem_enable_o || !cpu_stall_o || mem_write_o !== w || mem_addr_o !== a || mem_data_o !== d)
                ok = 1'b0;
        end
        check(tag, ok, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i          = 1'b0;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        mem_data_i     = '0;
        mem_ack_i      = 1'b0;
        repeat (2) tick();
        #1;
        check("rst_stall", cpu_stall_o, 1'b0);
        check("rst_mem_enable", mem_enable_o, 1'b0);
        check("rst_mem_write", mem_write_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
        tick();
        rst_i = 1'b1;

        // Cold load miss at 0x4, clean victim -> refill from 0x0
        cpu_addr_i    = 32'h0000_0004;
        cpu_MemRead_i = 1'b1;
        #1;
        check("t1_miss_stall", cpu_stall_o, 1'b1);
        check("t1_miss_no_mem_yet", mem_enable_o, 1'b0);
        wait_mem_enable("t1_refill_req");
        check("t1_refill_write", mem_write_o, 1'b0);
        check("t1_refill_addr", mem_addr_o, 32'h0);
        check("t1_refill_stall", cpu_stall_o, 1'b1);
        hold_stable("t1_refill_hold", 2);
        mem_data_i = LINE1;
        mem_ack_i  = 1'b1;
        #1;
        check("t1_fill_sram_write", sram_write_o, 1'b1);
        check("t1_fill_tag", sram_tag_o, 25'h100_0000);
        check("t1_fill_data", sram_data_o, LINE1);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("t1_done_stall", cpu_stall_o, 1'b1);
        check("t1_done_mem_drop", mem_enable_o, 1'b0);
        tick();
        check("t1_hit_stall", cpu_stall_o, 1'b0);
        check("t1_hit_data", cpu_data_o, 32'hDEAD_BEEF);
        tick();
        cpu_MemRead_i = 1'b0;

        // Repeat load hits in the same cycle
        cpu_addr_i    = 32'h0000_0004;
        cpu_MemRead_i = 1'b1;
        #1;
        check("t2_hit_stall", cpu_stall_o, 1'b0);
        check("t2_hit_data", cpu_data_o, 32'hDEAD_BEEF);
        check("t2_no_mem", mem_enable_o, 1'b0);
        tick();
        cpu_MemRead_i = 1'b0;

        // Store hit to word 2 of line 0
        cpu_addr_i     = 32'h0000_0008;
        cpu_data_i     = 32'h1234_5678;
        cpu_MemWrite_i = 1'b1;
        #1;
        check("t3_store_stall", cpu_stall_o, 1'b0);
        check("t3_store_write", sram_write_o, 1'b1);
        check("t3_store_tag", sram_tag_o, 25'h180_0000);
        check("t3_store_data", sram_data_o, LINE1_ST);
        tick();
        cpu_MemWrite_i = 1'b0;
        cpu_MemRead_i  = 1'b1;
        #1;
        check("t3_readback", cpu_data_o, 32'h1234_5678);
        tick();
        cpu_MemRead_i = 1'b0;

        // Fill way 1 of set 0 with 0x200 (victim is the invalid way)
        cpu_addr_i    = 32'h0000_0200;
        cpu_MemRead_i = 1'b1;
        #1;
        check("t4a_miss_stall", cpu_stall_o, 1'b1);
        wait_mem_enable("t4a_refill_req");
        check("t4a_refill_write", mem_write_o, 1'b0);
        check("t4a_refill_addr", mem_addr_o, 32'h0000_0200);
        mem_data_i = LINE2;
        mem_ack_i  = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick();
        check("t4a_hit_stall", cpu_stall_o, 1'b0);
        check("t4a_hit_data", cpu_data_o, 32'h2000_0000);
        tick();
        cpu_MemRead_i = 1'b0;

        // Load 0x400: dirty way 0 (line 0x0) is evicted first
        cpu_addr_i    = 32'h0000_0400;
        cpu_MemRead_i = 1'b1;
        #1;
        wait_mem_enable("t4b_wb_req");
        check("t4b_wb_write", mem_write_o, 1'b1);
        check("t4b_wb_addr", mem_addr_o, 32'h0);
        check("t4b_wb_data", mem_data_o, LINE1_ST);
        hold_stable("t4b_wb_hold5", 5);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("t4b_refill_en", mem_enable_o, 1'b1);
        check("t4b_refill_write", mem_write_o, 1'b0);
        check("t4b_refill_addr", mem_addr_o, 32'h0000_0400);
        check("t4b_refill_stall", cpu_stall_o, 1'b1);

        // Slow refill: request held for 10 cycles before the ack
        hold_stable("t5_refill_hold10", 10);
        mem_data_i = LINE3;
        mem_ack_i  = 1'b1;
        #1;
        check("t5_fill_tag", sram_tag_o, 25'h100_0002);
        tick();
        mem_ack_i = 1'b0;
        tick();
        check("t5_hit_stall", cpu_stall_o, 1'b0);
        check("t5_hit_data", cpu_data_o, 32'hA000_0000);
        tick();
        cpu_MemRead_i = 1'b0;
        mem_ack_i     = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("t5_spurious_no_req", mem_enable_o, 1'b0);
        check("t5_spurious_no_stall", cpu_stall_o, 1'b0);
        tick();
        cpu_MemRead_i = 1'b1;
        #1;
        check("t5_post_spurious_hit", cpu_stall_o, 1'b0);
        tick();
        cpu_MemRead_i = 1'b0;

        // Dirty both ways, then reset in the middle of a writeback
        cpu_addr_i     = 32'h0000_0404;
        cpu_data_i     = 32'hCAFE_F00D;
        cpu_MemWrite_i = 1'b1;
        #1;
        check("t6_store1_stall", cpu_stall_o, 1'b0);
        tick();
        cpu_addr_i = 32'h0000_0200;
        cpu_data_i = 32'hBBBB_0000;
        #1;
        check("t6_store2_stall", cpu_stall_o, 1'b0);
        tick();
        cpu_MemWrite_i = 1'b0;
        cpu_addr_i     = 32'h0000_0600;
        cpu_MemRead_i  = 1'b1;
        #1;
        wait_mem_enable("t6_wb_req");
        check("t6_wb_write", mem_write_o, 1'b1);
        check("t6_wb_addr", mem_addr_o, 32'h0000_0400);
        rst_i = 1'b0;
        #1;
        check("t6_rst_en", mem_enable_o, 1'b0);
        check("t6_rst_write", mem_write_o, 1'b0);
        check("t6_rst_addr", mem_addr_o, 32'h0);
        check("t6_rst_mdata", mem_data_o, 256'h0);
        check("t6_rst_stall", cpu_stall_o, 1'b0);
        check("t6_rst_sram_write", sram_write_o, 1'b0);
        check("t6_rst_cpu_data", cpu_data_o, 32'h0);
        tick();
        tick();
        cpu_MemRead_i = 1'b0;
        rst_i         = 1'b1;
        mem_ack_i     = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("t6_late_ack_en", mem_enable_o, 1'b0);
        check("t6_late_ack_stall", cpu_stall_o, 1'b0);
        tick();
        cpu_addr_i    = 32'h0000_0404;
        cpu_MemRead_i = 1'b1;
        #1;
        check("t6_after_rst_stall", cpu_stall_o, 1'b0);
        check("t6_after_rst_data", cpu_data_o, 32'hCAFE_F00D);
        tick();
        cpu_MemRead_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
